// File: rtl/chess_gfx_pkg.sv
// Shared chess graphics types: piece codes, framebuffer geometry, 12-bit RGB
// and the chroma-key test used by every sprite path.
package chess_gfx_pkg;

    typedef enum logic [3:0] {
        W_KING, W_QUEEN, W_ROOK, W_BISHOP, W_KNIGHT, W_PAWN,
        B_KING, B_QUEEN, B_ROOK, B_BISHOP, B_KNIGHT, B_PAWN
    } piece_t;

    localparam int NUM_PIECES = 12;
    localparam int FB_W       = 640;
    localparam int FB_H       = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, FINISH} blit_state_t;

    // Background colour: no green and red equal to blue (black included).
    function automatic logic is_chroma(rgb12_t c);
        return (c.g == 4'h0) && (c.r == c.b);
    endfunction

endpackage

// File: rtl/piece_blitter_if.sv
// Framebuffer write port: valid/ready with address and RGB payload.
interface piece_blitter_if;
    import chess_gfx_pkg::*;

    logic        fb_valid;
    logic        fb_ready;
    logic [18:0] fb_addr;
    rgb12_t      fb_data;

    modport master (output fb_valid, fb_addr, fb_data, input fb_ready);
    modport slave  (input fb_valid, fb_addr, fb_data, output fb_ready);
endinterface

// File: rtl/blit_addr_gen.sv
// Sprite pixel walker: col/row counters plus ROM, destination and
// framebuffer address arithmetic for the current pixel.
module blit_addr_gen
    import chess_gfx_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int FB_W     = chess_gfx_pkg::FB_W,
    parameter int FB_H     = chess_gfx_pkg::FB_H,
    localparam int CW      = $clog2(SPRITE_W),
    localparam int RW      = $clog2(SPRITE_H)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              clr,
    input  logic              adv,
    input  piece_t            piece,
    input  logic [9:0]        x0,
    input  logic [8:0]        y0,
    output logic [3+CW+RW:0]  rom_addr,
    output logic [10:0]       px,
    output logic [9:0]        py,
    output logic              clipped,
    output logic              last,
    output logic [18:0]       fb_addr
);
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_end;

    assign col_end = (col == CW'(SPRITE_W - 1));
    assign last    = col_end && (row == RW'(SPRITE_H - 1));

    // Row-major walk; both counters wrap to zero after the final pixel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            col <= col + 1'b1;
            if (col_end)
                row <= row + 1'b1;
        end
    end

    // Power-of-two sprite size turns piece*W*H + row*W + col into a concat.
    assign rom_addr = {piece, row, col};
    assign px       = 11'(x0) + 11'(col);
    assign py       = 10'(y0) + 10'(row);
    assign clipped  = (px >= 11'(FB_W)) || (py >= 10'(FB_H));
    assign fb_addr  = 19'(py) * 19'(FB_W) + 19'(px);

endmodule

// File: rtl/piece_blitter.sv
// Copies one chess-piece sprite into the framebuffer, dropping chroma-key
// and off-screen pixels. ROM has one cycle of latency; palette is combinational.
module piece_blitter
    import chess_gfx_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int FB_W     = chess_gfx_pkg::FB_W,
    parameter int FB_H     = chess_gfx_pkg::FB_H,
    localparam int AW      = 4 + $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   start,
    input  logic [3:0]             piece,
    input  logic [9:0]             x0,
    input  logic [8:0]             y0,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [AW-1:0]          rom_addr,
    input  logic [3:0]             rom_index,
    output logic [3:0]             pal_index,
    input  rgb12_t                 pal_rgb,
    piece_blitter_if.master        fb
);
    blit_state_t state_q, state_d;
    piece_t      piece_q;
    logic [9:0]  x0_q;
    logic [8:0]  y0_q;
    logic        err_q;
    logic [3:0]  pal_index_q;
    logic        legal, clr, adv, wr_req;
    logic        clipped, last;
    logic [10:0] px;
    logic [9:0]  py;
    logic [18:0] fb_addr_w;

    assign legal = (piece < 4'(NUM_PIECES));

    blit_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .FB_W     (FB_W),
        .FB_H     (FB_H)
    ) u_addr (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .clr      (clr),
        .adv      (adv),
        .piece    (piece_q),
        .x0       (x0_q),
        .y0       (y0_q),
        .rom_addr (rom_addr),
        .px       (px),
        .py       (py),
        .clipped  (clipped),
        .last     (last),
        .fb_addr  (fb_addr_w)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Blit parameters latched on start; ROM data captured into the palette index.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            piece_q     <= W_KING;
            x0_q        <= '0;
            y0_q        <= '0;
            err_q       <= 1'b0;
            pal_index_q <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                err_q <= !legal;
                if (legal) begin
                    piece_q <= piece_t'(piece);
                    x0_q    <= x0;
                    y0_q    <= y0;
                end
            end
            if (state_q == DATA)
                pal_index_q <= rom_index;
        end
    end

    // Next state, counter control and write request. Counters only move on a
    // skip or a completed handshake, so the write payload holds while stalled.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        adv     = 1'b0;
        wr_req  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = legal;
                    state_d = legal ? ADDR : FINISH;
                end
            end
            ADDR:  state_d = DATA;
            DATA:  state_d = WRITE;
            WRITE: begin
                wr_req = !(clipped || is_chroma(pal_rgb));
                if (!wr_req || fb.fb_ready) begin
                    adv     = 1'b1;
                    state_d = last ? FINISH : ADDR;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FINISH);
    assign err         = done && err_q;
    assign pal_index   = pal_index_q;
    assign fb.fb_valid = wr_req;
    assign fb.fb_addr  = wr_req ? fb_addr_w : '0;
    assign fb.fb_data  = wr_req ? pal_rgb : '0;

endmodule

// File: tb/tb_piece_blitter.sv
// Directed bench for piece_blitter with a registered sprite-ROM model and a
// combinational palette model.
module tb_piece_blitter;
    import chess_gfx_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  piece = 4'd0;
    logic [9:0]  x0 = 10'd0;
    logic [8:0]  y0 = 9'd0;
    logic        busy, done, err;
    logic [13:0] rom_addr;
    logic [3:0]  rom_index;
    logic [3:0]  pal_index;
    rgb12_t      pal_rgb;

    piece_blitter_if fb();

    piece_blitter dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .piece     (piece),
        .x0        (x0),
        .y0        (y0),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rom_addr  (rom_addr),
        .rom_index (rom_index),
        .pal_index (pal_index),
        .pal_rgb   (pal_rgb),
        .fb        (fb)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int mode = 0;  // 0: opaque pattern, 1: alternating 0/4

    // Palette: entry 0 is a chroma key colour, 4 is white, rest have green=8.
    function automatic logic [11:0] pal_fn(logic [3:0] i);
        if (i == 4'd0) return 12'h303;
        if (i == 4'd4) return 12'hFFF;
        return {i, 4'h8, ~i};
    endfunction

    function automatic logic [3:0] rom_fn(logic [13:0] a, int m);
        if (m == 1) return a[0] ? 4'd4 : 4'd0;
        return (a[3:0] == 4'd0) ? 4'd1 : a[3:0];
    endfunction

    always @(posedge Clk) rom_index <= rom_fn(rom_addr, mode);
    assign pal_rgb = pal_fn(pal_index);

    // Write monitor, sampled on the falling edge.
    int          wr_cnt, seq_bad, data_bad, not_fff, even_col, rom_chg;
    logic [18:0] first_addr, last_addr;
    logic [13:0] prev_rom;
    int          exp_x, exp_y, exp_pc;

    always @(negedge Clk) begin
        int k, ea;
        if (rom_addr !== prev_rom) rom_chg++;
        prev_rom = rom_addr;
        if (fb.fb_valid === 1'b1 && fb.fb_ready === 1'b1) begin
            k  = wr_cnt;
            ea = (exp_y + k / 32) * 640 + exp_x + k % 32;
            if (fb.fb_addr !== 19'(ea)) seq_bad++;
            if (fb.fb_data !== pal_fn(rom_fn(14'(exp_pc * 1024 + k), 0))) data_bad++;
            if (fb.fb_data !== 12'hFFF) not_fff++;
            if (fb.fb_addr[0] !== 1'b1) even_col++;
            if (wr_cnt == 0) first_addr = fb.fb_addr;
            last_addr = fb.fb_addr;
            wr_cnt++;
        end
    end

    int          stall_req = 0;
    int          stall_bad;

    task automatic clear_stats();
        wr_cnt = 0; seq_bad = 0; data_bad = 0; not_fff = 0; even_col = 0;
        rom_chg = 0; prev_rom = rom_addr; stall_bad = 0;
    endtask

    // Starts a blit and waits (bounded) for done; lat counts cycles from start.
    task automatic run_blit(input logic [3:0] p, input logic [9:0] x, input logic [8:0] y,
                            output int lat, output logic e, output logic [13:0] ra1);
        int          stalled;
        logic        hs_done;
        logic [18:0] cap_a;
        logic [11:0] cap_d;
        stalled = 0; hs_done = 1'b0; cap_a = '0; cap_d = '0;
        exp_pc = p; exp_x = x; exp_y = y;
        clear_stats();
        @(posedge Clk); #1;
        start = 1'b1; piece = p; x0 = x; y0 = y;
        fb.fb_ready = (stall_req == 0);
        @(posedge Clk); #1;
        start = 1'b0;
        lat = 1;
        ra1 = rom_addr;
        forever begin
            if (done === 1'b1 || lat >= 6000) break;
            if (stall_req > 0 && stalled == stall_req) begin
                fb.fb_ready = 1'b1;
                if (!hs_done && fb.fb_valid) begin
                    if (fb.fb_addr !== cap_a || fb.fb_data !== cap_d) stall_bad++;
                    hs_done = 1'b1;
                end
            end
            if (fb.fb_valid && !fb.fb_ready) begin
                if (stalled == 0) begin
                    cap_a = fb.fb_addr; cap_d = fb.fb_data;
                end else if (fb.fb_addr !== cap_a || fb.fb_data !== cap_d) begin
                    stall_bad++;
                end
                stalled++;
            end
            @(posedge Clk); #1;
            lat++;
        end
        e = err;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks += 8;
        if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)        begin failures++; $display("FAIL reset_done got %b want 0", done); end
        if (err !== 1'b0)         begin failures++; $display("FAIL reset_err got %b want 0", err); end
        if (fb.fb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", fb.fb_valid); end
        if (rom_addr !== 14'd0)   begin failures++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        if (pal_index !== 4'd0)   begin failures++; $display("FAIL reset_pal_index got %0d want 0", pal_index); end
        if (fb.fb_addr !== 19'd0) begin failures++; $display("FAIL reset_fb_addr got %0d want 0", fb.fb_addr); end
        if (fb.fb_data !== 12'd0) begin failures++; $display("FAIL reset_fb_data got %h want 0", fb.fb_data); end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_opaque();
        int lat; logic e; logic [13:0] ra;
        mode = 0; stall_req = 0;
        run_blit(4'd0, 10'd0, 9'd0, lat, e, ra);
        checks += 4;
        if (wr_cnt != 1024) begin failures++; $display("FAIL opaque_writes got %0d want 1024", wr_cnt); end
        if (seq_bad != 0)   begin failures++; $display("FAIL opaque_addr_seq got %0d bad want 0", seq_bad); end
        if (data_bad != 0)  begin failures++; $display("FAIL opaque_data got %0d bad want 0", data_bad); end
        if (lat != 3073)    begin failures++; $display("FAIL opaque_latency got %0d want 3073", lat); end
    endtask

    task automatic test_mixed();
        int lat; logic e; logic [13:0] ra;
        mode = 1; stall_req = 0;
        run_blit(4'd0, 10'd0, 9'd0, lat, e, ra);
        checks += 4;
        if (wr_cnt != 512) begin failures++; $display("FAIL mixed_writes got %0d want 512", wr_cnt); end
        if (not_fff != 0)  begin failures++; $display("FAIL mixed_data got %0d non-FFF want 0", not_fff); end
        if (even_col != 0) begin failures++; $display("FAIL mixed_odd_col got %0d even want 0", even_col); end
        if (lat != 3073)   begin failures++; $display("FAIL mixed_latency got %0d want 3073", lat); end
        mode = 0;
    endtask

    task automatic test_clip();
        int lat; logic e; logic [13:0] ra;
        mode = 0; stall_req = 0;
        run_blit(4'd0, 10'd620, 9'd470, lat, e, ra);
        checks += 3;
        if (wr_cnt != 200)           begin failures++; $display("FAIL clip_writes got %0d want 200", wr_cnt); end
        if (last_addr !== 19'd307199) begin failures++; $display("FAIL clip_last_addr got %0d want 307199", last_addr); end
        if (lat != 3073)             begin failures++; $display("FAIL clip_latency got %0d want 3073", lat); end
    endtask

    task automatic test_backpressure();
        int lat; logic e; logic [13:0] ra;
        mode = 0; stall_req = 5;
        run_blit(4'd0, 10'd0, 9'd0, lat, e, ra);
        stall_req = 0;
        fb.fb_ready = 1'b1;
        checks += 3;
        if (stall_bad != 0) begin failures++; $display("FAIL stall_stable got %0d changes want 0", stall_bad); end
        if (lat != 3078)    begin failures++; $display("FAIL stall_latency got %0d want 3078", lat); end
        if (wr_cnt != 1024) begin failures++; $display("FAIL stall_writes got %0d want 1024", wr_cnt); end
    endtask

    task automatic test_illegal();
        int lat; logic e; logic [13:0] ra;
        mode = 0; stall_req = 0;
        run_blit(4'd13, 10'd5, 9'd5, lat, e, ra);
        checks += 4;
        if (lat != 1)       begin failures++; $display("FAIL illegal_latency got %0d want 1", lat); end
        if (e !== 1'b1)     begin failures++; $display("FAIL illegal_err got %b want 1", e); end
        if (rom_chg != 0)   begin failures++; $display("FAIL illegal_rom_addr got %0d changes want 0", rom_chg); end
        if (wr_cnt != 0)    begin failures++; $display("FAIL illegal_writes got %0d want 0", wr_cnt); end
        // A start coincident with done must be dropped.
        start = 1'b1; piece = 4'd2;
        @(posedge Clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0)  begin failures++; $display("FAIL start_on_done got busy=%b want 0", busy); end
        run_blit(4'd2, 10'd0, 9'd0, lat, e, ra);
        checks += 5;
        if (ra !== 14'd2048) begin failures++; $display("FAIL piece2_rom_base got %0d want 2048", ra); end
        if (wr_cnt != 1024)  begin failures++; $display("FAIL piece2_writes got %0d want 1024", wr_cnt); end
        if (data_bad != 0)   begin failures++; $display("FAIL piece2_data got %0d bad want 0", data_bad); end
        if (lat != 3073)     begin failures++; $display("FAIL piece2_latency got %0d want 3073", lat); end
        if (e !== 1'b0)      begin failures++; $display("FAIL piece2_err got %b want 0", e); end
    endtask

    task automatic test_reset_mid();
        int lat; logic e; logic [13:0] ra;
        mode = 0; stall_req = 0;
        fb.fb_ready = 1'b0;
        @(posedge Clk); #1;
        start = 1'b1; piece = 4'd0; x0 = 10'd0; y0 = 9'd0;
        @(posedge Clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !fb.fb_valid; i++) begin
            @(posedge Clk); #1;
        end
        checks++;
        if (fb.fb_valid !== 1'b1) begin failures++; $display("FAIL midrst_stall_seen got %b want 1", fb.fb_valid); end
        repeat (2) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        checks += 2;
        if (fb.fb_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %b want 0", fb.fb_valid); end
        if (busy !== 1'b0)        begin failures++; $display("FAIL midrst_busy got %b want 0", busy); end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        fb.fb_ready = 1'b1;
        run_blit(4'd0, 10'd0, 9'd0, lat, e, ra);
        checks += 4;
        if (wr_cnt != 1024)        begin failures++; $display("FAIL midrst_writes got %0d want 1024", wr_cnt); end
        if (first_addr !== 19'd0)  begin failures++; $display("FAIL midrst_first_addr got %0d want 0", first_addr); end
        if (seq_bad != 0)          begin failures++; $display("FAIL midrst_addr_seq got %0d bad want 0", seq_bad); end
        if (lat != 3073)           begin failures++; $display("FAIL midrst_latency got %0d want 3073", lat); end
    endtask

    initial begin
        fb.fb_ready = 1'b1;
        exp_x = 0; exp_y = 0; exp_pc = 0;
        clear_stats();
        test_reset();
        test_opaque();
        test_mixed();
        test_clip();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
